// File: rtl/spike_event_encoder_pkg.sv
// Shared types and constants for the spike address-event encoder.
package spike_pkg;

    localparam int N_NEURONS      = 16;
    localparam int ADDR_WIDTH     = $clog2(N_NEURONS);
    localparam int TS_WIDTH       = 16;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_DROP_WIDTH = 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [TS_WIDTH-1:0]   stamp;
    } spike_event_t;

    // Index of the lowest set bit; returns 0 when no bit is set.
    function automatic logic [ADDR_WIDTH-1:0] lowest_set(input logic [N_NEURONS-1:0] v);
        logic [ADDR_WIDTH-1:0] idx;
        idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (v[i]) idx = ADDR_WIDTH'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/spike_event_encoder_if.sv
// Address-event stream from the encoder toward routing/off-chip logic.
interface spike_event_encoder_if;
    import spike_pkg::*;

    logic                  ev_valid;
    logic                  ev_ready;
    logic [ADDR_WIDTH-1:0] ev_addr;
    logic [TS_WIDTH-1:0]   ev_time;

    modport master (output ev_valid, output ev_addr, output ev_time, input ev_ready);
    modport slave  (input ev_valid, input ev_addr, input ev_time, output ev_ready);

endinterface

// File: rtl/spike_event_encoder_fifo.sv
// First-word-fall-through event FIFO; push and pop may coincide, even when full.
module spike_fifo
    import spike_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  spike_event_t           push_data,
    input  logic                   pop,
    output spike_event_t           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    spike_event_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every variable gets its default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count qualifies every read, and this keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/spike_event_encoder.sv
// Rising-edge to address-event encoder with timestamping, lowest-index arbitration and FWFT buffering.
// Optional macro SPIKE_DROP_COUNTER_EN adds a saturating lost-event counter on port drop_count.
module spike_event_encoder
    import spike_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
`ifdef SPIKE_DROP_COUNTER_EN
    ,
    parameter int DROP_WIDTH = DEF_DROP_WIDTH
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_NEURONS-1:0]  spike_in,
    input  logic [N_NEURONS-1:0]  enable_mask,
    input  logic                  ts_clear,
    spike_event_encoder_if.master ev,
    output logic                  fifo_full
`ifdef SPIKE_DROP_COUNTER_EN
    ,
    output logic [DROP_WIDTH-1:0] drop_count
`endif
);

    logic [TS_WIDTH-1:0]       ts_q, ts_d;
    logic [N_NEURONS-1:0]      prev_q;
    logic [N_NEURONS-1:0]      pending_q, pending_d;
    logic [TS_WIDTH-1:0]       stamp_q [N_NEURONS];
    logic [N_NEURONS-1:0]      rise_w;
    logic [N_NEURONS-1:0]      grant_oh;
    logic [N_NEURONS-1:0]      stamp_load;
    logic                      grant_valid;
    logic [ADDR_WIDTH-1:0]     grant_idx;
    logic                      push, pop;
    logic                      fifo_full_w, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    spike_event_t              push_data, head;

    assign rise_w      = spike_in & ~prev_q & enable_mask;
    assign grant_valid = |pending_q;
    assign grant_idx   = lowest_set(pending_q);
    assign pop         = !fifo_empty && ev.ev_ready;
    assign push        = grant_valid && (!fifo_full_w || pop);
    assign push_data   = '{addr: grant_idx, stamp: stamp_q[grant_idx]};
    assign ts_d        = ts_clear ? '0 : ts_q + TS_WIDTH'(1);

    // A new edge on a neuron whose event leaves this cycle re-arms it; otherwise a pending neuron drops it.
    always_comb begin
        grant_oh = '0;
        if (push) grant_oh[grant_idx] = 1'b1;
        pending_d  = (pending_q & ~grant_oh) | rise_w;
        stamp_load = rise_w & (~pending_q | grant_oh);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q      <= '0;
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            ts_q      <= ts_d;
            prev_q    <= spike_in;
            pending_q <= pending_d;
        end
    end

    // Stamps are only ever read behind a set pending bit, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_NEURONS; i++) begin
            if (stamp_load[i]) stamp_q[i] <= ts_q;
        end
    end

    spike_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full_w),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fifo_full   = (fifo_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_addr  = fifo_empty ? '0 : head.addr;
    assign ev.ev_time  = fifo_empty ? '0 : head.stamp;

`ifdef SPIKE_DROP_COUNTER_EN
    localparam int LCW = $clog2(N_NEURONS + 1);

    logic [N_NEURONS-1:0]  lost_w;
    logic [LCW-1:0]        lost_cnt;
    logic [DROP_WIDTH:0]   drop_sum;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    assign lost_w = rise_w & pending_q & ~grant_oh;

    always_comb begin
        lost_cnt = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            lost_cnt = lost_cnt + LCW'(lost_w[i]);
        end
        drop_sum = {1'b0, drop_q} + (DROP_WIDTH+1)'(lost_cnt);
        drop_d   = drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_q <= '0;
        else          drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed self-checking bench for spike_event_encoder (default and SPIKE_DROP_COUNTER_EN builds).
module tb_spike_event_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] spike_in;
    logic [15:0] enable_mask;
    logic        ts_clear;
    logic        fifo_full;
`ifdef SPIKE_DROP_COUNTER_EN
    logic [7:0]  drop_count;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    spike_event_encoder_if ev_if ();

    spike_event_encoder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spike_in    (spike_in),
        .enable_mask (enable_mask),
        .ts_clear    (ts_clear),
        .ev          (ev_if),
        .fifo_full   (fifo_full)
`ifdef SPIKE_DROP_COUNTER_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After this, the timestamp counter holds n.
    task automatic set_ts(input int n);
        ts_clear = 1'b1;
        tick();
        ts_clear = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ev_if.ev_valid); else pass_cnt++;
        total_cnt++; if (fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", fifo_full); else pass_cnt++;
        total_cnt++; if (ev_if.ev_addr !== 4'd0) $display("FAIL reset_addr: got %0d want 0", ev_if.ev_addr); else pass_cnt++;
        total_cnt++; if (ev_if.ev_time !== 16'd0) $display("FAIL reset_time: got %0d want 0", ev_if.ev_time); else pass_cnt++;
`ifdef SPIKE_DROP_COUNTER_EN
        total_cnt++; if (drop_count !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_count); else pass_cnt++;
`endif
    endtask

    task automatic test_single_spike();
        ev_if.ev_ready = 1'b1;
        set_ts(10);
        spike_in[5] = 1'b1;
        tick();
        total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL single_early: got %b want 0", ev_if.ev_valid); else pass_cnt++;
        tick();
        total_cnt++; if (ev_if.ev_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", ev_if.ev_valid); else pass_cnt++;
        total_cnt++; if (ev_if.ev_addr !== 4'd5) $display("FAIL single_addr: got %0d want 5", ev_if.ev_addr); else pass_cnt++;
        total_cnt++; if (ev_if.ev_time !== 16'd10) $display("FAIL single_time: got %0d want 10", ev_if.ev_time); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL single_once[%0d]: got %b want 0", i, ev_if.ev_valid); else pass_cnt++;
        end
        spike_in = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_addr [3];
        exp_addr[0] = 4'd1; exp_addr[1] = 4'd3; exp_addr[2] = 4'd7;
        ev_if.ev_ready = 1'b1;
        set_ts(20);
        spike_in = 16'h008A;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            total_cnt++; if (ev_if.ev_valid !== 1'b1) $display("FAIL simul_valid[%0d]: got %b want 1", k, ev_if.ev_valid); else pass_cnt++;
            total_cnt++; if (ev_if.ev_addr !== exp_addr[k]) $display("FAIL simul_addr[%0d]: got %0d want %0d", k, ev_if.ev_addr, exp_addr[k]); else pass_cnt++;
            total_cnt++; if (ev_if.ev_time !== 16'd20) $display("FAIL simul_time[%0d]: got %0d want 20", k, ev_if.ev_time); else pass_cnt++;
            tick();
        end
        total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL simul_done: got %b want 0", ev_if.ev_valid); else pass_cnt++;
        spike_in = '0;
        tick();
    endtask

    task automatic test_backpressure();
        ev_if.ev_ready = 1'b0;
        set_ts(3);
        spike_in = 16'h01FF;
        tick();
        repeat (7) tick();
        total_cnt++; if (fifo_full !== 1'b0) $display("FAIL bp_seven: got %b want 0", fifo_full); else pass_cnt++;
        repeat (3) tick();
        total_cnt++; if (fifo_full !== 1'b1) $display("FAIL bp_full: got %b want 1", fifo_full); else pass_cnt++;
        total_cnt++; if (ev_if.ev_addr !== 4'd0) $display("FAIL bp_hold: got %0d want 0", ev_if.ev_addr); else pass_cnt++;
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            total_cnt++; if (ev_if.ev_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, ev_if.ev_valid); else pass_cnt++;
            total_cnt++; if (ev_if.ev_addr !== 4'(i)) $display("FAIL bp_addr[%0d]: got %0d want %0d", i, ev_if.ev_addr, i); else pass_cnt++;
            total_cnt++; if (ev_if.ev_time !== 16'd3) $display("FAIL bp_time[%0d]: got %0d want 3", i, ev_if.ev_time); else pass_cnt++;
            tick();
        end
        total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", ev_if.ev_valid); else pass_cnt++;
        total_cnt++; if (fifo_full !== 1'b0) $display("FAIL bp_notfull: got %b want 0", fifo_full); else pass_cnt++;
`ifdef SPIKE_DROP_COUNTER_EN
        total_cnt++; if (drop_count !== 8'd0) $display("FAIL bp_nodrop: got %0d want 0", drop_count); else pass_cnt++;
`endif
        spike_in = '0;
        tick();
    endtask

    task automatic test_loss();
        logic [3:0] exp_addr [9];
        for (int i = 0; i < 8; i++) exp_addr[i] = 4'(8 + i);
        exp_addr[8] = 4'd2;
        ev_if.ev_ready = 1'b0;
        spike_in = 16'hFF00;
        tick();
        repeat (10) tick();
        total_cnt++; if (fifo_full !== 1'b1) $display("FAIL loss_full: got %b want 1", fifo_full); else pass_cnt++;
        spike_in[2] = 1'b1; tick();
        spike_in[2] = 1'b0; tick();
        spike_in[2] = 1'b1; tick();
        spike_in[2] = 1'b0; tick();
`ifdef SPIKE_DROP_COUNTER_EN
        total_cnt++; if (drop_count !== 8'd1) $display("FAIL loss_drop: got %0d want 1", drop_count); else pass_cnt++;
`endif
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            total_cnt++; if (ev_if.ev_valid !== 1'b1) $display("FAIL loss_valid[%0d]: got %b want 1", i, ev_if.ev_valid); else pass_cnt++;
            total_cnt++; if (ev_if.ev_addr !== exp_addr[i]) $display("FAIL loss_addr[%0d]: got %0d want %0d", i, ev_if.ev_addr, exp_addr[i]); else pass_cnt++;
            tick();
        end
        total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL loss_once: got %b want 0", ev_if.ev_valid); else pass_cnt++;
        spike_in = '0;
        tick();
    endtask

    task automatic test_mask_wrap();
        ev_if.ev_ready = 1'b1;
        enable_mask[4] = 1'b0;
        spike_in[4] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL mask_quiet[%0d]: got %b want 0", i, ev_if.ev_valid); else pass_cnt++;
        end
        enable_mask = '1;
        repeat (3) tick();
        total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL mask_level: got %b want 0", ev_if.ev_valid); else pass_cnt++;
        spike_in = '0;
        tick();
        force dut.ts_q = 16'hFFFF;
        #1;
        release dut.ts_q;
        spike_in[0] = 1'b1;
        tick();
        spike_in[1] = 1'b1;
        tick();
        total_cnt++; if (ev_if.ev_addr !== 4'd0) $display("FAIL wrap_addr0: got %0d want 0", ev_if.ev_addr); else pass_cnt++;
        total_cnt++; if (ev_if.ev_time !== 16'hFFFF) $display("FAIL wrap_time0: got %h want ffff", ev_if.ev_time); else pass_cnt++;
        tick();
        total_cnt++; if (ev_if.ev_addr !== 4'd1) $display("FAIL wrap_addr1: got %0d want 1", ev_if.ev_addr); else pass_cnt++;
        total_cnt++; if (ev_if.ev_time !== 16'h0000) $display("FAIL wrap_time1: got %h want 0000", ev_if.ev_time); else pass_cnt++;
        tick();
        total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL wrap_done: got %b want 0", ev_if.ev_valid); else pass_cnt++;
        spike_in = '0;
        tick();
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_addr [3];
        exp_addr[0] = 4'd2; exp_addr[1] = 4'd6; exp_addr[2] = 4'd9;
        ev_if.ev_ready = 1'b0;
        set_ts(50);
        spike_in = 16'h0244;
        tick();
        repeat (4) tick();
        total_cnt++; if (ev_if.ev_time !== 16'd50) $display("FAIL ar_queued: got %0d want 50", ev_if.ev_time); else pass_cnt++;
        #3 reset_n = 1'b0;
        #1;
        total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL ar_valid: got %b want 0", ev_if.ev_valid); else pass_cnt++;
        total_cnt++; if (ev_if.ev_addr !== 4'd0) $display("FAIL ar_addr: got %0d want 0", ev_if.ev_addr); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        ev_if.ev_ready = 1'b1;
        tick();
        total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL ar_empty: got %b want 0", ev_if.ev_valid); else pass_cnt++;
        tick();
        for (int k = 0; k < 3; k++) begin
            total_cnt++; if (ev_if.ev_addr !== exp_addr[k]) $display("FAIL ar_addr[%0d]: got %0d want %0d", k, ev_if.ev_addr, exp_addr[k]); else pass_cnt++;
            total_cnt++; if (ev_if.ev_time !== 16'd0) $display("FAIL ar_time[%0d]: got %0d want 0", k, ev_if.ev_time); else pass_cnt++;
            tick();
        end
        total_cnt++; if (ev_if.ev_valid !== 1'b0) $display("FAIL ar_done: got %b want 0", ev_if.ev_valid); else pass_cnt++;
        spike_in = '0;
        tick();
    endtask

    initial begin
        reset_n        = 1'b0;
        spike_in       = '0;
        enable_mask    = '1;
        ts_clear       = 1'b0;
        ev_if.ev_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_single_spike();
        test_simultaneous();
        test_backpressure();
        test_loss();
        test_mask_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
